// File: rtl/decoder.sv
// Registered instruction decoder for the 16-bit playground CPU: splits the
// fetched word into register indices, a sign-extended immediate and stage strobes.
module decoder #(
  parameter int XLEN = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     instr,
  output logic [3:0]      opcode,
  output logic [2:0]      rd,
  output logic [2:0]      rs1,
  output logic [2:0]      rs2,
  output logic [2:0]      alu_op,
  output logic [XLEN-1:0] imm,
  output logic            use_imm,
  output logic            reg_we,
  output logic            mem_re,
  output logic            mem_we,
  output logic            branch,
  output logic [2:0]      br_cond,
  output logic            jump,
  output logic            link,
  output logic            halt,
  output logic            illegal
);

  typedef struct packed {
    logic [3:0]      opcode;
    logic [2:0]      rd;
    logic [2:0]      rs1;
    logic [2:0]      rs2;
    logic [2:0]      alu_op;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
    logic            branch;
    logic [2:0]      br_cond;
    logic            jump;
    logic            link;
    logic            halt;
    logic            illegal;
  } dec_t;

  localparam logic [3:0] OP_ALUR = 4'h0;
  localparam logic [3:0] OP_ALUI = 4'h1;
  localparam logic [3:0] OP_LOAD = 4'h2;
  localparam logic [3:0] OP_STOR = 4'h3;
  localparam logic [3:0] OP_BRCH = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_JAL  = 4'h6;
  localparam logic [3:0] OP_JR   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [2:0] ALU_ADD = 3'd0;

  function automatic logic [XLEN-1:0] sext6(input logic [5:0] f);
    return {{(XLEN-6){f[5]}}, f};
  endfunction

  function automatic logic [XLEN-1:0] sext9(input logic [8:0] f);
    return {{(XLEN-9){f[8]}}, f};
  endfunction

  dec_t w_dec;
  dec_t r_dec;

  always_comb begin
    w_dec        = '0;
    w_dec.opcode = instr[15:12];
    case (instr[15:12])
      OP_ALUR: begin
        w_dec.rd     = instr[11:9];
        w_dec.rs1    = instr[8:6];
        w_dec.rs2    = instr[5:3];
        w_dec.alu_op = instr[2:0];
        w_dec.reg_we = 1'b1;
      end
      OP_ALUI: begin
        w_dec.rd      = instr[11:9];
        w_dec.rs1     = instr[8:6];
        w_dec.alu_op  = instr[2:0];
        w_dec.imm     = sext6(instr[5:0]);
        w_dec.use_imm = 1'b1;
        w_dec.reg_we  = 1'b1;
      end
      OP_LOAD: begin
        w_dec.rd      = instr[11:9];
        w_dec.rs1     = instr[8:6];
        w_dec.rs2     = instr[5:3];
        w_dec.alu_op  = ALU_ADD;
        w_dec.imm     = sext6(instr[5:0]);
        w_dec.use_imm = 1'b1;
        w_dec.mem_re  = 1'b1;
        w_dec.reg_we  = 1'b1;
      end
      // Store data register lives in the rd slot; ALU forms rs1 + imm as address.
      OP_STOR: begin
        w_dec.rs1     = instr[8:6];
        w_dec.rs2     = instr[11:9];
        w_dec.alu_op  = ALU_ADD;
        w_dec.imm     = sext6(instr[5:0]);
        w_dec.use_imm = 1'b1;
        w_dec.mem_we  = 1'b1;
      end
      OP_BRCH: begin
        w_dec.branch  = 1'b1;
        w_dec.br_cond = instr[11:9];
        w_dec.imm     = sext9(instr[8:0]);
      end
      OP_LDI: begin
        w_dec.rd      = instr[11:9];
        w_dec.alu_op  = ALU_ADD;
        w_dec.imm     = sext9(instr[8:0]);
        w_dec.use_imm = 1'b1;
        w_dec.reg_we  = 1'b1;
      end
      OP_JAL: begin
        w_dec.rd     = instr[11:9];
        w_dec.imm    = sext9(instr[8:0]);
        w_dec.jump   = 1'b1;
        w_dec.link   = 1'b1;
        w_dec.reg_we = 1'b1;
      end
      OP_JR: begin
        w_dec.rs1  = instr[8:6];
        w_dec.jump = 1'b1;
      end
      OP_HALT: w_dec.halt = 1'b1;
      default: w_dec.illegal = 1'b1;
    endcase
    // r0 is hardwired zero, so a write to it is dropped here.
    if (w_dec.rd == 3'd0) w_dec.reg_we = 1'b0;
  end

  // Decode -> execute register stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_dec <= '0;
    else        r_dec <= w_dec;
  end

  assign opcode  = r_dec.opcode;
  assign rd      = r_dec.rd;
  assign rs1     = r_dec.rs1;
  assign rs2     = r_dec.rs2;
  assign alu_op  = r_dec.alu_op;
  assign imm     = r_dec.imm;
  assign use_imm = r_dec.use_imm;
  assign reg_we  = r_dec.reg_we;
  assign mem_re  = r_dec.mem_re;
  assign mem_we  = r_dec.mem_we;
  assign branch  = r_dec.branch;
  assign br_cond = r_dec.br_cond;
  assign jump    = r_dec.jump;
  assign link    = r_dec.link;
  assign halt    = r_dec.halt;
  assign illegal = r_dec.illegal;

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder: expected decodes are queued when an instruction
// is driven and popped when its registered decode appears one cycle later.
module tb_decoder;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  alu_op;
    logic [15:0] imm;
    logic        use_imm;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic [2:0]  br_cond;
    logic        jump;
    logic        link;
    logic        halt;
    logic        illegal;
  } dec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr = 16'h025a;
  logic [3:0]  opcode;
  logic [2:0]  rd, rs1, rs2, alu_op, br_cond;
  logic [15:0] imm;
  logic        use_imm, reg_we, mem_re, mem_we, branch, jump, link, halt, illegal;

  dec_t obs;
  dec_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  decoder #(.XLEN(16)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .alu_op(alu_op),
    .imm(imm), .use_imm(use_imm), .reg_we(reg_we), .mem_re(mem_re),
    .mem_we(mem_we), .branch(branch), .br_cond(br_cond), .jump(jump),
    .link(link), .halt(halt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs = {opcode, rd, rs1, rs2, alu_op, imm, use_imm, reg_we, mem_re,
                mem_we, branch, br_cond, jump, link, halt, illegal};

  task automatic check(input string tag, input dec_t o, input dec_t e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Drive on the falling edge, queue the expectation, compare just after the next rising edge.
  task automatic step(input logic [15:0] ins, input dec_t e);
    dec_t got;
    @(negedge clk);
    instr = ins;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s observed=empty_queue expected=entry", $sformatf("q_%h", ins));
    end else begin
      got = sb_q.pop_front();
      check($sformatf("dec_%h", ins), obs, got);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_t e;
    dec_t e_alur;

    // Outputs stay zero in reset despite clocking a live instruction.
    #2;
    check("rst_async", obs, dec_t'('0));
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_hold", obs, dec_t'('0));
    end

    e_alur = '0; e_alur.rd = 3'd1; e_alur.rs1 = 3'd1; e_alur.rs2 = 3'd3;
    e_alur.alu_op = 3'd2; e_alur.reg_we = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    step(16'h025a, e_alur);

    e = '0; e.opcode = 4'h1; e.rd = 3'd1; e.rs1 = 3'd1; e.alu_op = 3'd7;
    e.imm = 16'hFFFF; e.use_imm = 1'b1; e.reg_we = 1'b1;
    step(16'h127F, e);

    e = '0; e.opcode = 4'h5; e.rd = 3'd5; e.imm = 16'h0055; e.use_imm = 1'b1; e.reg_we = 1'b1;
    step(16'h5A55, e);

    e = '0; e.opcode = 4'h5; e.rd = 3'd1; e.imm = 16'hFF00; e.use_imm = 1'b1; e.reg_we = 1'b1;
    step(16'h5300, e);

    e = '0; e.opcode = 4'h2; e.rd = 3'd1; e.rs1 = 3'd1; e.rs2 = 3'd2; e.imm = 16'h0010;
    e.use_imm = 1'b1; e.mem_re = 1'b1; e.reg_we = 1'b1;
    step(16'h2250, e);

    e = '0; e.opcode = 4'h3; e.rs1 = 3'd1; e.rs2 = 3'd3; e.imm = 16'h0010;
    e.use_imm = 1'b1; e.mem_we = 1'b1;
    step(16'h3650, e);

    e = '0; e.opcode = 4'h4; e.branch = 1'b1; e.br_cond = 3'd1; e.imm = 16'hFF00;
    step(16'h4300, e);

    e = '0; e.opcode = 4'h6; e.rd = 3'd7; e.imm = 16'h0004; e.jump = 1'b1; e.link = 1'b1;
    e.reg_we = 1'b1;
    step(16'h6E04, e);

    e = '0; e.opcode = 4'h6; e.imm = 16'h0004; e.jump = 1'b1; e.link = 1'b1;
    step(16'h6004, e);

    e = '0; e.opcode = 4'h7; e.rs1 = 3'd1; e.jump = 1'b1;
    step(16'h7040, e);

    step(16'h0000, dec_t'('0));

    e = '0; e.opcode = 4'h8; e.illegal = 1'b1;
    step(16'h8000, e);

    e = '0; e.opcode = 4'hE; e.illegal = 1'b1;
    step(16'hE123, e);

    e = '0; e.opcode = 4'hF; e.halt = 1'b1;
    step(16'hF000, e);

    // Back-to-back stream: every decode lands exactly one cycle after its instruction.
    step(16'h025a, e_alur);
    e = '0; e.opcode = 4'h2; e.rd = 3'd1; e.rs1 = 3'd1; e.rs2 = 3'd2; e.imm = 16'h0010;
    e.use_imm = 1'b1; e.mem_re = 1'b1; e.reg_we = 1'b1;
    step(16'h2250, e);
    e = '0; e.opcode = 4'h4; e.branch = 1'b1; e.br_cond = 3'd1; e.imm = 16'hFF00;
    step(16'h4300, e);

    // Mid-cycle reset clears outputs without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_async", obs, dec_t'('0));
    @(posedge clk); #1;
    check("rst_mid_hold", obs, dec_t'('0));
    @(negedge clk);
    reset = 1'b1;
    step(16'h025a, e_alur);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
